pipeline_perf_monitor: RTL and testbench

- Synthesizable performance and run-control monitor for the pipelined RV64 core. Replaces ad-hoc bench-side cycle counting and post-halt drain waits.
- Observes retire, stall, flush and end_program signals from the pipeline.
- Keeps saturating per-class instruction counters plus NUM_EVT generic event counters, with a run/drain/done state machine.
- Exposes an indexed counter readout with a valid/ready handshake, readable by a bench or debug host.

---
 rtl/perf_pkg.sv | 39 +++
 rtl/perf_sat_counter.sv | 29 ++
 rtl/pipeline_perf_monitor.sv | 164 ++++++++++++++++
 tb/tb_pipeline_perf_monitor.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared types and constants for the pipeline performance monitor.
// Counter index map, RV opcode constants and derived sizing helpers.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } perf_state_e;

  localparam int unsigned CNT_CYCLES  = 0;
  localparam int unsigned CNT_RETIRED = 1;
  localparam int unsigned CNT_STALL   = 2;
  localparam int unsigned CNT_FLUSH   = 3;
  localparam int unsigned CNT_R       = 4;
  localparam int unsigned CNT_IALU    = 5;
  localparam int unsigned CNT_LOAD    = 6;
  localparam int unsigned CNT_STORE   = 7;
  localparam int unsigned CNT_BRANCH  = 8;
  localparam int unsigned CNT_OTHER   = 9;
  localparam int unsigned CNT_EVT0    = 10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  function automatic int unsigned num_cnt(input int unsigned num_evt);
    return 10 + num_evt;
  endfunction

  // One extra index beyond the counters addresses the overflow mask.
  function automatic int unsigned idx_w(input int unsigned num_evt);
    return $clog2(num_cnt(num_evt) + 1);
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with synchronous clear; ovf_pulse flags an
// increment attempted while already at all-ones.
module perf_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf_pulse
);

  logic at_max;

  assign at_max    = &cnt;
  assign ovf_pulse = inc && at_max && !clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Retire/stall/flush performance monitor with run/drain/done control and
// an indexed readout port. Optional overflow IRQ: PERF_OVERFLOW_IRQ_EN.
module pipeline_perf_monitor
  import perf_pkg::*;
#(
  parameter  int unsigned CNT_W        = 32,
  parameter  int unsigned NUM_EVT      = 4,
  parameter  int unsigned DRAIN_CYCLES = 5,
  localparam int unsigned NUM_CNT      = num_cnt(NUM_EVT),
  localparam int unsigned IDX_W        = idx_w(NUM_EVT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_en,
  input  logic               clear,
  input  logic               end_program,
  input  logic               retire_valid,
  input  logic [31:0]        retire_instr,
  input  logic               stall,
  input  logic               flush,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               rd_req,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [CNT_W-1:0]   rd_data,
  output logic [1:0]         state,
  output logic               done,
  output logic               ovf_irq
);

  localparam int unsigned DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  perf_state_e       state_q, next_state;
  logic [DR_W-1:0]   drain_q;
  logic              active;
  logic              qual_retire;
  logic [6:0]        opcode;
  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] ovf_pulse;
  logic [CNT_W-1:0]  cnt_q [NUM_CNT];
  logic [CNT_W-1:0]  mask_word;
  logic [CNT_W-1:0]  sel;
  logic              rd_accept;

  // ---------------- run control ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  always_comb begin
    next_state = state_q;
    case (state_q)
      ST_IDLE:  if (!clear && run_en)  next_state = ST_RUN;
      ST_RUN:   if (end_program)       next_state = ST_DRAIN;
      ST_DRAIN: if (drain_q == '0)     next_state = ST_DONE;
      ST_DONE:  if (clear)             next_state = ST_IDLE;
      default:                         next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain_q <= '0;
    end else if (state_q == ST_RUN && end_program) begin
      drain_q <= DR_W'(DRAIN_CYCLES - 1);
    end else if (state_q == ST_DRAIN && drain_q != '0) begin
      drain_q <= drain_q - DR_W'(1);
    end
  end

  assign state = state_q;
  assign done  = (state_q == ST_DONE);

  // ---------------- event qualification ----------------
  assign active      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  // An all-zero instruction word is a bubble and counts nowhere.
  assign qual_retire = retire_valid && (retire_instr != '0);
  assign opcode      = retire_instr[6:0];

  always_comb begin
    inc              = '0;
    inc[CNT_CYCLES]  = active;
    inc[CNT_RETIRED] = active && qual_retire;
    inc[CNT_STALL]   = active && stall;
    inc[CNT_FLUSH]   = active && flush;
    case (opcode)
      OP_R:      inc[CNT_R]      = active && qual_retire;
      OP_IALU:   inc[CNT_IALU]   = active && qual_retire;
      OP_LOAD:   inc[CNT_LOAD]   = active && qual_retire;
      OP_STORE:  inc[CNT_STORE]  = active && qual_retire;
      OP_BRANCH: inc[CNT_BRANCH] = active && qual_retire;
      default:   inc[CNT_OTHER]  = active && qual_retire;
    endcase
    for (int unsigned k = 0; k < NUM_EVT; k++) begin
      inc[CNT_EVT0 + k] = active && evt[k];
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    perf_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .clr       (clear),
      .inc       (inc[g]),
      .cnt       (cnt_q[g]),
      .ovf_pulse (ovf_pulse[g])
    );
  end

  // ---------------- overflow flags ----------------
`ifdef PERF_OVERFLOW_IRQ_EN
  localparam int unsigned MW = (NUM_CNT < CNT_W) ? NUM_CNT : CNT_W;

  logic [NUM_CNT-1:0] ovf_flags;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_flags <= '0;
    end else if (clear) begin
      ovf_flags <= '0;
    end else begin
      ovf_flags <= ovf_flags | ovf_pulse;
    end
  end

  assign mask_word = CNT_W'(ovf_flags[MW-1:0]);
  assign ovf_irq   = |ovf_flags;
`else
  logic unused_ovf;

  assign unused_ovf = |ovf_pulse;
  assign mask_word  = '0;
  assign ovf_irq    = 1'b0;
`endif

  // ---------------- readout ----------------
  always_comb begin
    sel = '0;
    if (rd_idx == IDX_W'(NUM_CNT)) sel = mask_word;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == IDX_W'(i)) sel = cnt_q[i];
    end
  end

  assign rd_accept = rd_req && (!rd_valid || rd_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (rd_accept) begin
      rd_valid <= 1'b1;
      rd_data  <= sel;
    end else if (rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Self-checking bench for pipeline_perf_monitor: directed scenarios plus
// randomized traffic against a per-cycle behavioural reference model.
module tb_pipeline_perf_monitor;
  import perf_pkg::*;

  localparam int unsigned CNT_W    = 32;
  localparam int unsigned NUM_EVT  = 4;
  localparam int unsigned DRAIN    = 5;
  localparam int unsigned NUM_CNT  = num_cnt(NUM_EVT);
  localparam int unsigned IDX_W    = idx_w(NUM_EVT);
  localparam longint unsigned MAXV = (64'd1 << CNT_W) - 64'd1;
`ifdef PERF_OVERFLOW_IRQ_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance stimulus
  logic               run_en, clear, end_program, retire_valid, stall, flush;
  logic [31:0]        retire_instr;
  logic [NUM_EVT-1:0] evt;
  logic               rd_req, rd_ready, rd_valid, done, ovf_irq;
  logic [IDX_W-1:0]   rd_idx;
  logic [CNT_W-1:0]   rd_data;
  logic [1:0]         state;

  // narrow instance for saturation
  logic               s_run_en, s_stall, s_rd_req, s_rd_valid, s_done, s_ovf_irq;
  logic [IDX_W-1:0]   s_rd_idx;
  logic [3:0]         s_rd_data;
  logic [1:0]         s_state;
  logic               s_zero;
  logic [31:0]        s_zero_instr;
  logic [NUM_EVT-1:0] s_zero_evt;

  pipeline_perf_monitor #(.CNT_W(CNT_W), .NUM_EVT(NUM_EVT), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset), .run_en(run_en), .clear(clear), .end_program(end_program),
    .retire_valid(retire_valid), .retire_instr(retire_instr), .stall(stall), .flush(flush),
    .evt(evt), .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .state(state), .done(done), .ovf_irq(ovf_irq)
  );

  pipeline_perf_monitor #(.CNT_W(4), .NUM_EVT(NUM_EVT), .DRAIN_CYCLES(DRAIN)) dut_sat (
    .clk(clk), .reset(reset), .run_en(s_run_en), .clear(s_zero), .end_program(s_zero),
    .retire_valid(s_zero), .retire_instr(s_zero_instr), .stall(s_stall), .flush(s_zero),
    .evt(s_zero_evt), .rd_req(s_rd_req), .rd_idx(s_rd_idx), .rd_valid(s_rd_valid),
    .rd_ready(1'b1), .rd_data(s_rd_data), .state(s_state), .done(s_done), .ovf_irq(s_ovf_irq)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int              m_state;
  int              m_drain_left;
  longint unsigned m_cnt [NUM_CNT];
  bit [NUM_CNT-1:0] m_flags;
  bit              m_rd_valid;
  longint unsigned m_rd_data;

  task automatic model_reset();
    m_state = 0; m_drain_left = 0; m_flags = '0;
    m_rd_valid = 0; m_rd_data = 0;
    for (int i = 0; i < NUM_CNT; i++) m_cnt[i] = 0;
  endtask

  function automatic longint unsigned mask_value();
    longint unsigned v = 0;
    for (int i = 0; i < NUM_CNT; i++) if (m_flags[i]) v |= (64'd1 << i);
    return OVF_EN ? (v & MAXV) : 64'd0;
  endfunction

  task automatic bump(input int i, input bit c);
    if (c) begin
      if (m_cnt[i] == MAXV) m_flags[i] = 1'b1;
      else m_cnt[i]++;
    end
  endtask

  task automatic model_step();
    bit act, qual;
    int cls, idx;
    act = (m_state == 1) || (m_state == 2);
    if (rd_req && (!m_rd_valid || rd_ready)) begin
      idx = int'(rd_idx);
      m_rd_valid = 1'b1;
      if (idx < NUM_CNT)       m_rd_data = m_cnt[idx];
      else if (idx == NUM_CNT) m_rd_data = mask_value();
      else                     m_rd_data = 0;
    end else if (rd_ready) begin
      m_rd_valid = 1'b0;
    end
    if (clear) begin
      for (int i = 0; i < NUM_CNT; i++) m_cnt[i] = 0;
      m_flags = '0;
    end else if (act) begin
      qual = retire_valid && (retire_instr != 32'd0);
      case (retire_instr[6:0])
        7'h33: cls = 4;
        7'h13: cls = 5;
        7'h03: cls = 6;
        7'h23: cls = 7;
        7'h63: cls = 8;
        default: cls = 9;
      endcase
      bump(0, 1'b1); bump(1, qual); bump(2, stall); bump(3, flush); bump(cls, qual);
      for (int k = 0; k < NUM_EVT; k++) bump(10 + k, evt[k]);
    end
    case (m_state)
      0: if (!clear && run_en) m_state = 1;
      1: if (end_program) begin m_state = 2; m_drain_left = DRAIN; end
      2: begin m_drain_left--; if (m_drain_left == 0) m_state = 3; end
      default: if (clear) m_state = 0;
    endcase
  endtask

  task automatic compare_all();
    check_eq("state", 64'(state), 64'(m_state));
    check_eq("done", 64'(done), 64'(m_state == 3));
    check_eq("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
    check_eq("rd_data", 64'(rd_data), m_rd_data);
    check_eq("ovf_irq", 64'(ovf_irq), 64'(OVF_EN && (m_flags != '0)));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    run_en = 0; clear = 0; end_program = 0; retire_valid = 0; retire_instr = '0;
    stall = 0; flush = 0; evt = '0; rd_req = 0; rd_idx = '0; rd_ready = 1;
  endtask

  task automatic read_idx(input int unsigned idx, output logic [63:0] val);
    rd_req = 1; rd_idx = IDX_W'(idx); rd_ready = 1;
    cycle();
    rd_req = 0;
    val = 64'(rd_data);
  endtask

  logic [31:0] prog [7];
  logic [63:0] v;
  logic [31:0] r;
  logic [6:0]  ops [7];

  initial begin
    prog[0] = 32'h00100093; prog[1] = 32'h00200113; prog[2] = 32'h002081B3;
    prog[3] = 32'h00003203; prog[4] = 32'h00403423; prog[5] = 32'h00000063;
    prog[6] = 32'h00000000;
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23;
    ops[4] = 7'h63; ops[5] = 7'h6F; ops[6] = 7'h37;

    idle_inputs();
    s_run_en = 0; s_stall = 0; s_rd_req = 0; s_rd_idx = '0;
    s_zero = 0; s_zero_instr = '0; s_zero_evt = '0;
    reset = 0;
    model_reset();
    #12 reset = 1;
    #1 compare_all();

    // saturation on the 4-bit instance
    s_run_en = 1; cycle(); s_run_en = 0;
    s_stall = 1;
    repeat (20) cycle();
    s_rd_req = 1; s_rd_idx = IDX_W'(2); cycle();
    check_eq("sat_stall", 64'(s_rd_data), 64'd15);
    s_rd_idx = IDX_W'(NUM_CNT); cycle();
    check_eq("sat_mask", 64'(s_rd_data), OVF_EN ? 64'd5 : 64'd0);
    check_eq("sat_irq", 64'(s_ovf_irq), 64'(OVF_EN));
    check_eq("sat_state", 64'(s_state), 64'd1);
    s_rd_req = 0; s_stall = 0;

    // basic program
    run_en = 1; cycle(); run_en = 0;
    for (int c = 1; c <= 12; c++) begin
      retire_valid = (c <= 7);
      retire_instr = (c <= 7) ? prog[c-1] : 32'd0;
      end_program  = (c == 12);
      cycle();
    end
    idle_inputs();
    check_eq("enter_drain", 64'(state), 64'd2);
    repeat (4) cycle();
    check_eq("drain_len", 64'(state), 64'd2);
    cycle();
    check_eq("done_state", 64'(state), 64'd3);
    read_idx(0, v); check_eq("prog_cycles", v, 64'd17);
    read_idx(1, v); check_eq("prog_retired", v, 64'd6);
    read_idx(4, v); check_eq("prog_r", v, 64'd1);
    read_idx(5, v); check_eq("prog_ialu", v, 64'd2);
    read_idx(6, v); check_eq("prog_load", v, 64'd1);
    read_idx(7, v); check_eq("prog_store", v, 64'd1);
    read_idx(8, v); check_eq("prog_branch", v, 64'd1);
    read_idx(9, v); check_eq("prog_other", v, 64'd0);

    // clear in DONE, then drain/freeze
    clear = 1; cycle(); clear = 0;
    check_eq("clear_done_idle", 64'(state), 64'd0);
    for (int i = 0; i < NUM_CNT; i++) begin
      read_idx(i, v); check_eq("cleared_cnt", v, 64'd0);
    end
    run_en = 1; cycle(); run_en = 0;
    repeat (3) cycle();
    end_program = 1; cycle(); end_program = 0;
    retire_valid = 1; retire_instr = prog[0]; cycle();
    retire_instr = prog[2]; end_program = 1; cycle();
    end_program = 0; retire_valid = 0;
    cycle(); cycle();
    check_eq("drain_no_restart", 64'(state), 64'd2);
    cycle();
    check_eq("drain_to_done", 64'(state), 64'd3);
    for (int i = 0; i < 10; i++) begin
      stall = 1; flush = 1; evt = NUM_EVT'($urandom);
      retire_valid = 1; retire_instr = prog[1];
      cycle();
    end
    idle_inputs();
    read_idx(1, v); check_eq("drain_retired", v, 64'd2);
    read_idx(2, v); check_eq("frozen_stall", v, 64'd0);

    // clear precedence in RUN
    clear = 1; cycle(); clear = 0;
    run_en = 1; cycle(); run_en = 0;
    stall = 1; clear = 1; cycle(); stall = 0; clear = 0;
    check_eq("clear_run_state", 64'(state), 64'd1);
    read_idx(2, v); check_eq("clear_wins", v, 64'd0);

    // readout backpressure
    rd_req = 1; rd_idx = IDX_W'(0); rd_ready = 0; cycle();
    rd_idx = IDX_W'(1);
    repeat (3) cycle();
    check_eq("bp_hold_valid", 64'(rd_valid), 64'd1);
    rd_ready = 1; cycle();
    rd_req = 0; cycle();
    read_idx(31, v); check_eq("idx_oob", v, 64'd0);

    // async reset in DRAIN with pending readout
    end_program = 1; cycle(); end_program = 0;
    rd_req = 1; rd_idx = IDX_W'(0); rd_ready = 0; cycle(); rd_req = 0;
    check_eq("pre_reset_valid", 64'(rd_valid), 64'd1);
    #3 reset = 0;
    model_reset();
    #1;
    check_eq("rst_state", 64'(state), 64'd0);
    check_eq("rst_valid", 64'(rd_valid), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1;
    rd_ready = 1;
    for (int i = 0; i <= NUM_CNT; i++) begin
      read_idx(i, v); check_eq("rst_cnt", v, 64'd0);
    end

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      r = $urandom();
      retire_valid = $urandom_range(0, 1);
      retire_instr = ($urandom_range(0, 7) == 0) ? 32'd0 : {r[31:7], ops[$urandom_range(0, 6)]};
      stall = $urandom_range(0, 1);
      flush = ($urandom_range(0, 3) == 0);
      evt = NUM_EVT'($urandom);
      clear = ($urandom_range(0, 59) == 0);
      run_en = ($urandom_range(0, 3) == 0);
      end_program = ($urandom_range(0, 39) == 0);
      rd_req = $urandom_range(0, 1);
      rd_idx = IDX_W'($urandom_range(0, NUM_CNT + 1));
      rd_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
